// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: ID/EX pipeline register with ALU control decode and operand forwarding.
// Ports:
//   clk_i, reset_i (async, active-high), stall_i (hold), flush_i (bubble)
//   id_*_i            decoded instruction fields and register-file read data
//   exmem_*_i         EX/MEM writeback enable, destination and ALU result
//   memwb_*_i         MEM/WB writeback enable, destination and writeback data
//   A_o, B_o          forwarded ALU operands
//   ALU_Ctl_o         registered 4-bit ALU control
//   ex_store_data_o   forwarded rt value for stores
//   ex_dest_o, ex_reg_write_o, ex_valid_o, ex_illegal_o  registered status
module id_ex_operand_stage #(
    parameter int WIDTH  = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              id_valid_i,
    input  logic [WIDTH-1:0]  id_rs_data_i,
    input  logic [WIDTH-1:0]  id_rt_data_i,
    input  logic [15:0]       id_imm_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic [1:0]        id_alu_op_i,
    input  logic [5:0]        id_funct_i,
    input  logic              id_alu_src_i,
    input  logic              id_reg_dst_i,
    input  logic              id_reg_write_i,
    input  logic              exmem_reg_write_i,
    input  logic [REG_AW-1:0] exmem_rd_i,
    input  logic [WIDTH-1:0]  exmem_result_i,
    input  logic              memwb_reg_write_i,
    input  logic [REG_AW-1:0] memwb_rd_i,
    input  logic [WIDTH-1:0]  memwb_result_i,
    output logic [WIDTH-1:0]  A_o,
    output logic [WIDTH-1:0]  B_o,
    output logic [3:0]        ALU_Ctl_o,
    output logic [WIDTH-1:0]  ex_store_data_o,
    output logic [REG_AW-1:0] ex_dest_o,
    output logic              ex_reg_write_o,
    output logic              ex_valid_o,
    output logic              ex_illegal_o
);
    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [WIDTH-1:0]  rs_data;
        logic [WIDTH-1:0]  rt_data;
        logic [WIDTH-1:0]  imm;
        logic              alu_src;
        logic [3:0]        alu_ctl;
        logic [REG_AW-1:0] dest;
        logic              reg_write;
        logic              illegal;
    } stage_t;
    stage_t stage_d, stage_q;
    logic [3:0] rtype_ctl;
    logic       rtype_ok;
    logic       illegal;
    logic [WIDTH-1:0] fwd_rs, fwd_rt;
    always_comb begin
        rtype_ok  = id_funct_i inside {6'b100000, 6'b100010, 6'b100100,
                                       6'b100101, 6'b101010, 6'b100111};
        rtype_ctl = (id_funct_i == 6'b100010) ? 4'b0110 :
                    (id_funct_i == 6'b100100) ? 4'b0000 :
                    (id_funct_i == 6'b100101) ? 4'b0001 :
                    (id_funct_i == 6'b101010) ? 4'b0111 :
                    (id_funct_i == 6'b100111) ? 4'b1100 : 4'b0010;
        illegal   = (id_alu_op_i == 2'b10) && !rtype_ok;
        stage_d   = '0;
        if (id_valid_i) begin
            stage_d.valid     = 1'b1;
            stage_d.rs        = id_rs_i;
            stage_d.rt        = id_rt_i;
            stage_d.rs_data   = id_rs_data_i;
            stage_d.rt_data   = id_rt_data_i;
            // ori zero-extends its immediate; every other op sign-extends
            stage_d.imm       = (id_alu_op_i == 2'b11) ? {{(WIDTH-16){1'b0}}, id_imm_i}
                                                      : {{(WIDTH-16){id_imm_i[15]}}, id_imm_i};
            stage_d.alu_src   = id_alu_src_i;
            stage_d.alu_ctl   = (id_alu_op_i == 2'b00) ? 4'b0010 :
                                (id_alu_op_i == 2'b01) ? 4'b0110 :
                                (id_alu_op_i == 2'b11) ? 4'b0001 : rtype_ctl;
            stage_d.dest      = id_reg_dst_i ? id_rd_i : id_rt_i;
            stage_d.reg_write = id_reg_write_i && !illegal;
            stage_d.illegal   = illegal;
        end
    end
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i || flush_i)
            stage_q <= '0;
        else if (!stall_i)
            stage_q <= stage_d;
    end
    // EX/MEM is the younger producer, so it wins over MEM/WB; r0 is never forwarded
    assign fwd_rs = (stage_q.rs != '0 && exmem_reg_write_i && exmem_rd_i == stage_q.rs) ? exmem_result_i :
                    (stage_q.rs != '0 && memwb_reg_write_i && memwb_rd_i == stage_q.rs) ? memwb_result_i :
                    stage_q.rs_data;
    assign fwd_rt = (stage_q.rt != '0 && exmem_reg_write_i && exmem_rd_i == stage_q.rt) ? exmem_result_i :
                    (stage_q.rt != '0 && memwb_reg_write_i && memwb_rd_i == stage_q.rt) ? memwb_result_i :
                    stage_q.rt_data;
    assign A_o             = fwd_rs;
    assign B_o             = stage_q.alu_src ? stage_q.imm : fwd_rt;
    assign ex_store_data_o = fwd_rt;
    assign ALU_Ctl_o       = stage_q.alu_ctl;
    assign ex_dest_o       = stage_q.dest;
    assign ex_reg_write_o  = stage_q.reg_write;
    assign ex_valid_o      = stage_q.valid;
    assign ex_illegal_o    = stage_q.illegal;
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb_id_ex_operand_stage: directed vector bench for the ID/EX operand stage.
module tb_id_ex_operand_stage;
    logic        clk = 1'b0;
    logic        reset, stall, flush, id_valid;
    logic [31:0] id_rs_data, id_rt_data;
    logic [15:0] id_imm;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [1:0]  id_alu_op;
    logic [5:0]  id_funct;
    logic        id_alu_src, id_reg_dst, id_reg_write;
    logic        exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_result;
    logic [31:0] a, b, store;
    logic [3:0]  ctl;
    logic [4:0]  dest;
    logic        rw, valid, ill;
    int tests = 0;
    int fails = 0;
    always #5 clk = ~clk;
    id_ex_operand_stage dut (
        .clk_i(clk), .reset_i(reset), .stall_i(stall), .flush_i(flush),
        .id_valid_i(id_valid), .id_rs_data_i(id_rs_data), .id_rt_data_i(id_rt_data),
        .id_imm_i(id_imm), .id_rs_i(id_rs), .id_rt_i(id_rt), .id_rd_i(id_rd),
        .id_alu_op_i(id_alu_op), .id_funct_i(id_funct), .id_alu_src_i(id_alu_src),
        .id_reg_dst_i(id_reg_dst), .id_reg_write_i(id_reg_write),
        .exmem_reg_write_i(exmem_reg_write), .exmem_rd_i(exmem_rd), .exmem_result_i(exmem_result),
        .memwb_reg_write_i(memwb_reg_write), .memwb_rd_i(memwb_rd), .memwb_result_i(memwb_result),
        .A_o(a), .B_o(b), .ALU_Ctl_o(ctl), .ex_store_data_o(store), .ex_dest_o(dest),
        .ex_reg_write_o(rw), .ex_valid_o(valid), .ex_illegal_o(ill)
    );
    typedef struct {
        logic        v;
        logic [31:0] rsd, rtd;
        logic [15:0] imm;
        logic [4:0]  rs, rt, rd;
        logic [1:0]  op;
        logic [5:0]  fn;
        logic        src, dst, wr;
        logic        xw;
        logic [4:0]  xrd;
        logic [31:0] xres;
        logic        ww;
        logic [4:0]  wrd;
        logic [31:0] wres;
        logic [31:0] ea, eb, es;
        logic [3:0]  ectl;
        logic [4:0]  ed;
        logic        erw, ev, eil;
    } vec_t;
    vec_t vecs[16];
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask
    task automatic drive(input vec_t t);
        id_valid = t.v; id_rs_data = t.rsd; id_rt_data = t.rtd; id_imm = t.imm;
        id_rs = t.rs; id_rt = t.rt; id_rd = t.rd; id_alu_op = t.op; id_funct = t.fn;
        id_alu_src = t.src; id_reg_dst = t.dst; id_reg_write = t.wr;
        exmem_reg_write = t.xw; exmem_rd = t.xrd; exmem_result = t.xres;
        memwb_reg_write = t.ww; memwb_rd = t.wrd; memwb_result = t.wres;
    endtask
    task automatic check_vec(input string tag, input vec_t t);
        chk({tag, " A"}, a, t.ea);
        chk({tag, " B"}, b, t.eb);
        chk({tag, " store"}, store, t.es);
        chk({tag, " ctl"}, {28'h0, ctl}, {28'h0, t.ectl});
        chk({tag, " dest"}, {27'h0, dest}, {27'h0, t.ed});
        chk({tag, " reg_write"}, {31'h0, rw}, {31'h0, t.erw});
        chk({tag, " valid"}, {31'h0, valid}, {31'h0, t.ev});
        chk({tag, " illegal"}, {31'h0, ill}, {31'h0, t.eil});
    endtask
    initial begin
        // v rsd rtd imm rs rt rd op fn src dst wr | xw xrd xres | ww wrd wres | ea eb es ctl dest rw valid ill
        vecs[0]  = '{1'b1, 32'h1398_9207, 32'h1234_5678, 16'h0, 5'd1, 5'd2, 5'd3, 2'b10, 6'b100000, 1'b0, 1'b1, 1'b1,
                     1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                     32'h1398_9207, 32'h1234_5678, 32'h1234_5678, 4'b0010, 5'd3, 1'b1, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 32'h11, 32'h22, 16'h8001, 5'd1, 5'd2, 5'd7, 2'b11, 6'b0, 1'b1, 1'b0, 1'b1,
                     1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                     32'h11, 32'h0000_8001, 32'h22, 4'b0001, 5'd2, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 32'h11, 32'h22, 16'h8001, 5'd1, 5'd2, 5'd7, 2'b00, 6'b0, 1'b1, 1'b0, 1'b1,
                     1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                     32'h11, 32'hFFFF_8001, 32'h22, 4'b0010, 5'd2, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 32'd100, 32'd30, 16'h0, 5'd1, 5'd2, 5'd4, 2'b01, 6'b0, 1'b0, 1'b1, 1'b1,
                     1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                     32'd100, 32'd30, 32'd30, 4'b0110, 5'd4, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 32'h5, 32'h6, 16'h0, 5'd5, 5'd6, 5'd7, 2'b10, 6'b100000, 1'b0, 1'b1, 1'b1,
                     1'b1, 5'd5, 32'hAAAA_0000, 1'b1, 5'd5, 32'h5555_0000,
                     32'hAAAA_0000, 32'h6, 32'h6, 4'b0010, 5'd7, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 32'h5, 32'h6, 16'h0, 5'd5, 5'd6, 5'd7, 2'b10, 6'b100000, 1'b0, 1'b1, 1'b1,
                     1'b0, 5'd5, 32'hAAAA_0000, 1'b1, 5'd5, 32'h5555_0000,
                     32'h5555_0000, 32'h6, 32'h6, 4'b0010, 5'd7, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 32'h0, 32'h6, 16'h0, 5'd0, 5'd6, 5'd7, 2'b10, 6'b100000, 1'b0, 1'b1, 1'b1,
                     1'b1, 5'd0, 32'hDEAD_BEEF, 1'b1, 5'd6, 32'h77,
                     32'h0, 32'h77, 32'h77, 4'b0010, 5'd7, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 32'h3, 32'h9, 16'h0004, 5'd8, 5'd9, 5'd7, 2'b00, 6'b0, 1'b1, 1'b0, 1'b1,
                     1'b1, 5'd9, 32'hCAFE, 1'b0, 5'd0, 32'h0,
                     32'h3, 32'h4, 32'hCAFE, 4'b0010, 5'd9, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 32'h1, 32'h2, 16'h0, 5'd1, 5'd2, 5'd3, 2'b10, 6'b100100, 1'b0, 1'b1, 1'b1,
                     1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                     32'h1, 32'h2, 32'h2, 4'b0000, 5'd3, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 32'h1, 32'h2, 16'h0, 5'd1, 5'd2, 5'd3, 2'b10, 6'b100101, 1'b0, 1'b1, 1'b1,
                     1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                     32'h1, 32'h2, 32'h2, 4'b0001, 5'd3, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 32'h1, 32'h2, 16'h0, 5'd1, 5'd2, 5'd3, 2'b10, 6'b101010, 1'b0, 1'b1, 1'b1,
                     1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                     32'h1, 32'h2, 32'h2, 4'b0111, 5'd3, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 32'h1, 32'h2, 16'h0, 5'd1, 5'd2, 5'd3, 2'b10, 6'b100111, 1'b0, 1'b1, 1'b1,
                     1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                     32'h1, 32'h2, 32'h2, 4'b1100, 5'd3, 1'b1, 1'b1, 1'b0};
        vecs[12] = '{1'b1, 32'h1, 32'h2, 16'h0, 5'd1, 5'd2, 5'd3, 2'b10, 6'b100010, 1'b0, 1'b1, 1'b1,
                     1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                     32'h1, 32'h2, 32'h2, 4'b0110, 5'd3, 1'b1, 1'b1, 1'b0};
        vecs[13] = '{1'b1, 32'h1, 32'h2, 16'h0, 5'd1, 5'd2, 5'd3, 2'b10, 6'b000111, 1'b0, 1'b1, 1'b1,
                     1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                     32'h1, 32'h2, 32'h2, 4'b0010, 5'd3, 1'b0, 1'b1, 1'b1};
        vecs[14] = '{1'b0, 32'h55, 32'h66, 16'hFFFF, 5'd1, 5'd2, 5'd3, 2'b01, 6'b100000, 1'b0, 1'b1, 1'b1,
                     1'b1, 5'd0, 32'h1234, 1'b1, 5'd0, 32'h5678,
                     32'h0, 32'h0, 32'h0, 4'b0000, 5'd0, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{1'b1, 32'h1, 32'h2, 16'h0, 5'd1, 5'd2, 5'd3, 2'b10, 6'b100101, 1'b0, 1'b1, 1'b0,
                     1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                     32'h1, 32'h2, 32'h2, 4'b0001, 5'd3, 1'b0, 1'b1, 1'b0};
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        drive(vecs[0]);
        repeat (2) @(posedge clk);
        #1;
        chk("reset valid", {31'h0, valid}, 32'h0);
        chk("reset ctl", {28'h0, ctl}, 32'h0);
        chk("reset dest", {27'h0, dest}, 32'h0);
        chk("reset reg_write", {31'h0, rw}, 32'h0);
        chk("reset illegal", {31'h0, ill}, 32'h0);
        @(negedge clk) reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk) drive(vecs[i]);
            @(posedge clk) #1;
            check_vec($sformatf("vec%0d", i), vecs[i]);
        end
        // asynchronous reset in the middle of a cycle with a valid instruction presented
        @(negedge clk) drive(vecs[0]);
        @(posedge clk) #1;
        chk("preload valid", {31'h0, valid}, 32'h1);
        #2 reset = 1'b1;
        #1;
        chk("async reset valid", {31'h0, valid}, 32'h0);
        chk("async reset ctl", {28'h0, ctl}, 32'h0);
        chk("async reset dest", {27'h0, dest}, 32'h0);
        @(negedge clk) reset = 1'b0;
        @(posedge clk) #1;
        check_vec("post reset", vecs[0]);
        // stall for three cycles while a different instruction is presented
        @(negedge clk) begin stall = 1'b1; drive(vecs[1]); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk) #1;
            check_vec($sformatf("stall%0d", i), vecs[0]);
        end
        @(negedge clk) flush = 1'b1;
        @(posedge clk) #1;
        chk("stall+flush valid", {31'h0, valid}, 32'h0);
        chk("stall+flush ctl", {28'h0, ctl}, 32'h0);
        chk("stall+flush reg_write", {31'h0, rw}, 32'h0);
        @(negedge clk) begin stall = 1'b0; flush = 1'b0; end
        @(posedge clk) #1;
        check_vec("resume", vecs[1]);
        @(negedge clk) flush = 1'b1;
        @(posedge clk) #1;
        chk("flush valid", {31'h0, valid}, 32'h0);
        chk("flush dest", {27'h0, dest}, 32'h0);
        @(negedge clk) flush = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
